// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Difference bit and borrow-out for one bit position.
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a_i - b_i LSB-first, one bit per clock,
// with a start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q, diff_q;
  logic [CntW-1:0]  cnt_q;
  logic             br_q, borrow_q;

  logic load;
  logic last;
  logic bit_diff, bit_bout;

  assign last = (cnt_q == CntW'(WIDTH - 1));

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (br_q),
    .diff (bit_diff),
    .bout (bit_bout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE may chain straight into another operation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs; start is only accepted outside SHIFT.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    load = start && (state_q != StShift);
  end

  // Operand shift registers, borrow flop, counter and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (load) begin
      a_sr_q <= a_i;
      b_sr_q <= b_i;
      br_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (busy) begin
      a_sr_q <= a_sr_q >> 1;
      b_sr_q <= b_sr_q >> 1;
      br_q   <= bit_bout;
      cnt_q  <= cnt_q + CntW'(1);
      res_q  <= {bit_diff, res_q[WIDTH-1:1]};
      // Publish on the final bit so outputs are valid while done is high.
      if (last) begin
        diff_q   <= {bit_diff, res_q[WIDTH-1:1]};
        borrow_q <= bit_bout;
      end
    end
  end

  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

endmodule
